// File: rtl/fm_demod.sv
// FM discriminator: conj(prev)*cur, quantized arctangent through an iterative divider, gain scaling.
// Optional output clamp to 16-bit range with a sticky sat_seen flag: define FM_DEMOD_SATURATE_EN.
module fm_demod #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter int unsigned          BITS      = 10,
  parameter logic [DATA_SIZE-1:0] GAIN      = DATA_SIZE'(32'h000002F6),
  parameter logic [DATA_SIZE-1:0] QUAD1     = DATA_SIZE'(32'h00000324),
  parameter logic [DATA_SIZE-1:0] QUAD3     = DATA_SIZE'(32'h0000096C)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_SIZE-1:0] real_in,
  input  logic                 real_empty,
  output logic                 real_rd_en,
  input  logic [DATA_SIZE-1:0] imag_in,
  input  logic                 imag_empty,
  output logic                 imag_rd_en,
  output logic [DATA_SIZE-1:0] demod_out,
  input  logic                 demod_full,
  output logic                 demod_wr_en
);

  localparam int unsigned W  = DATA_SIZE;
  localparam int unsigned WW = 2 * DATA_SIZE;
  localparam int unsigned CW = $clog2(DATA_SIZE);

  typedef logic signed [W-1:0]  word_t;
  typedef logic signed [WW-1:0] wide_t;

  typedef enum logic [2:0] {
    S_READ, S_MULT, S_SETUP, S_DIV, S_ANGLE, S_GAIN, S_WRITE
  } state_t;

  function automatic wide_t mul(input word_t a, input word_t b);
    wide_t ae;
    wide_t be;
    ae = wide_t'(a);
    be = wide_t'(b);
    return ae * be;
  endfunction

  // Dequantize with truncation toward zero, not the floor an arithmetic shift would give.
  function automatic wide_t deq_wide(input wide_t v);
    return (v < 0) ? -((-v) >>> BITS) : (v >>> BITS);
  endfunction

  function automatic word_t deq(input wide_t v);
    return word_t'(deq_wide(v));
  endfunction

  state_t         state;
  word_t          cur_real, cur_imag;
  word_t          prev_real, prev_imag;
  word_t          r_q, i_q;
  logic [W-1:0]   den_q;
  logic [W-1:0]   dvd_q;
  logic [W-1:0]   rem_q;
  logic           num_neg_q;
  logic [CW-1:0]  count_q;
  word_t          angle_q;
  word_t          result_q;
`ifdef FM_DEMOD_SATURATE_EN
  logic           sat_seen;
  logic           clamp;
  wide_t          gain_w;
`endif

  logic           pop;
  word_t          neg_pi;
  word_t          mult_r, mult_i;
  word_t          abs_y;
  word_t          num;
  word_t          den;
  logic [W-1:0]   num_mag;
  logic [W:0]     rem_sh;
  logic           take;
  logic [W-1:0]   rem_next;
  word_t          quot;
  word_t          angle;
  word_t          res;

  assign pop        = (state == S_READ) && !real_empty && !imag_empty;
  assign real_rd_en = pop;
  assign imag_rd_en = pop;

  always_comb begin
    neg_pi = -prev_imag;
    mult_r = deq(mul(prev_real, cur_real)) - deq(mul(neg_pi, cur_imag));
    mult_i = deq(mul(prev_real, cur_imag)) + deq(mul(neg_pi, cur_real));

    abs_y = ((i_q < 0) ? -i_q : i_q) + word_t'(1);
    if (r_q >= 0) begin
      num = (r_q - abs_y) <<< BITS;
      den = r_q + abs_y;
    end else begin
      num = (r_q + abs_y) <<< BITS;
      den = abs_y - r_q;
    end
    num_mag = (num < 0) ? -num : num;

    // Restoring step: quotient bits shift into the dividend register as it empties.
    rem_sh   = {rem_q, dvd_q[W-1]};
    take     = (rem_sh >= {1'b0, den_q});
    rem_next = take ? W'(rem_sh - {1'b0, den_q}) : rem_sh[W-1:0];

    quot  = num_neg_q ? -dvd_q : dvd_q;
    angle = ((r_q >= 0) ? word_t'(QUAD1) : word_t'(QUAD3)) - deq(mul(word_t'(QUAD1), quot));
    if (i_q < 0) angle = -angle;

`ifdef FM_DEMOD_SATURATE_EN
    gain_w = deq_wide(mul(word_t'(GAIN), angle_q));
    clamp  = 1'b0;
    if (gain_w > 32767) begin
      res   = word_t'(32767);
      clamp = 1'b1;
    end else if (gain_w < -32768) begin
      res   = word_t'(-32768);
      clamp = 1'b1;
    end else begin
      res = word_t'(gain_w);
    end
`else
    res = deq(mul(word_t'(GAIN), angle_q));
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_READ;
      cur_real    <= '0;
      cur_imag    <= '0;
      prev_real   <= '0;
      prev_imag   <= '0;
      r_q         <= '0;
      i_q         <= '0;
      den_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      num_neg_q   <= 1'b0;
      count_q     <= '0;
      angle_q     <= '0;
      result_q    <= '0;
      demod_out   <= '0;
      demod_wr_en <= 1'b0;
`ifdef FM_DEMOD_SATURATE_EN
      sat_seen    <= 1'b0;
`endif
    end else begin
      demod_wr_en <= 1'b0;
      case (state)
        S_READ: begin
          if (pop) begin
            cur_real <= real_in;
            cur_imag <= imag_in;
            state    <= S_MULT;
          end
        end
        S_MULT: begin
          r_q       <= mult_r;
          i_q       <= mult_i;
          prev_real <= cur_real;
          prev_imag <= cur_imag;
          state     <= S_SETUP;
        end
        S_SETUP: begin
          den_q     <= den;
          dvd_q     <= num_mag;
          num_neg_q <= (num < 0);
          rem_q     <= '0;
          count_q   <= CW'(W - 1);
          state     <= S_DIV;
        end
        S_DIV: begin
          rem_q   <= rem_next;
          dvd_q   <= {dvd_q[W-2:0], take};
          count_q <= count_q - 1'b1;
          if (count_q == '0) state <= S_ANGLE;
        end
        S_ANGLE: begin
          angle_q <= angle;
          state   <= S_GAIN;
        end
        S_GAIN: begin
          result_q <= res;
`ifdef FM_DEMOD_SATURATE_EN
          sat_seen <= sat_seen | clamp;
`endif
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (!demod_full) begin
            demod_out   <= result_q;
            demod_wr_en <= 1'b1;
            state       <= S_READ;
          end
        end
        default: state <= S_READ;
      endcase
    end
  end

endmodule
